// File: rtl/bp_update_queue.sv
// -----------------------------------------------------------------------------
// bp_update_queue
//   Buffers resolved conditional-branch outcomes from the EX-stage branch unit
//   and drains them, one per cycle, into the PHT write port. Also flags
//   mispredictions for the fetch-redirect logic and keeps saturating counts of
//   accepted branches and accepted mispredicted branches.
//
// Ports
//   clk            system clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   in_valid       EX presents a resolved branch
//   in_pc          PC of the resolved branch
//   in_taken       actual outcome (1 = taken)
//   in_pred_taken  prediction made at fetch for this branch
//   in_ready       queue can accept (= !full, combinational from count)
//   clr            synchronous queue flush, counters unaffected
//   upd_hold       suppress draining this cycle
//   upd_we         PHT write enable, one-cycle pulse per drained entry
//   upd_pc         PHT PC_actual
//   upd_taken      PHT is_taken_actual
//   mispredict     registered pulse per accepted mispredicted branch
//   count          entries held
//   full / empty   count == DEPTH / count == 0
//   branch_cnt     accepted branches, saturating
//   mispred_cnt    accepted mispredicted branches, saturating
// -----------------------------------------------------------------------------
module bp_update_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       in_taken,
    input  logic                       in_pred_taken,
    output logic                       in_ready,
    input  logic                       clr,
    input  logic                       upd_hold,
    output logic                       upd_we,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           branch_cnt,
    output logic [CNT_W-1:0]           mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CQ_W  = PTR_W + 1;
    localparam logic [CQ_W-1:0]  DEPTH_C = CQ_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Each entry stores {pc, taken}
    logic [PC_W:0]      mem_q [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CQ_W-1:0]    count_q, count_d;
    logic               upd_we_q, upd_we_d;
    logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
    logic               upd_taken_q, upd_taken_d;
    logic               mispredict_q, mispredict_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               miss_s;

    // Status flags come from the occupancy count, never from pointer compare
    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == {CQ_W{1'b0}});
    // Full blocks a push even when a pop happens on the same edge
    assign push_s  = in_valid & ~full_s & ~clr;
    assign pop_s   = ~empty_s & ~upd_hold & ~clr;
    assign miss_s  = push_s & (in_taken ^ in_pred_taken);

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[tail_q] <= {in_pc, in_taken};
        end
    end

    // Next-state for pointers, occupancy, drain port, mispredict and counters
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_we_d      = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        mispredict_d  = miss_s;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (clr) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CQ_W{1'b0}};
        end else begin
            // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 naturally
            if (push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end

            if (pop_s) begin
                head_d      = head_q + PTR_W'(1);
                upd_we_d    = 1'b1;
                upd_pc_d    = mem_q[head_q][PC_W:1];
                upd_taken_d = mem_q[head_q][0];
            end else begin
                head_d      = head_q;
                upd_we_d    = 1'b0;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CQ_W'(1);
                2'b01:   count_d = count_q - CQ_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (push_s && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end else begin
            branch_cnt_d = branch_cnt_q;
        end

        if (miss_s && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q        <= {PTR_W{1'b0}};
            tail_q        <= {PTR_W{1'b0}};
            count_q       <= {CQ_W{1'b0}};
            upd_we_q      <= 1'b0;
            upd_pc_q      <= {PC_W{1'b0}};
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_we_q      <= upd_we_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign in_ready    = ~full_s;
    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = count_q;
    assign upd_we      = upd_we_q;
    assign upd_pc      = upd_pc_q;
    assign upd_taken   = upd_taken_q;
    assign mispredict  = mispredict_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_update_queue.sv
module tb_bp_update_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_pc;
    logic        in_taken;
    logic        in_pred_taken;
    logic        clr;
    logic        upd_hold;

    logic        in_ready, upd_we, upd_taken, mispredict, full, empty;
    logic [15:0] upd_pc, branch_cnt, mispred_cnt;
    logic [2:0]  count;

    logic        s_in_ready, s_upd_we, s_upd_taken, s_mispredict, s_full, s_empty;
    logic [15:0] s_upd_pc;
    logic [2:0]  s_count;
    logic [3:0]  s_branch_cnt, s_mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain queue of {pc, taken} plus expected outputs
    logic [16:0] mq[$];
    logic        exp_we, exp_tk, exp_mis;
    logic [15:0] exp_pc;
    int          exp_bc, exp_mc, exp_bc4, exp_mc4;

    bp_update_queue #(.DEPTH(4), .PC_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_taken(in_taken), .in_pred_taken(in_pred_taken), .in_ready(in_ready),
        .clr(clr), .upd_hold(upd_hold), .upd_we(upd_we), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .mispredict(mispredict), .count(count),
        .full(full), .empty(empty), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    bp_update_queue #(.DEPTH(4), .PC_W(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_taken(in_taken), .in_pred_taken(in_pred_taken), .in_ready(s_in_ready),
        .clr(clr), .upd_hold(upd_hold), .upd_we(s_upd_we), .upd_pc(s_upd_pc),
        .upd_taken(s_upd_taken), .mispredict(s_mispredict), .count(s_count),
        .full(s_full), .empty(s_empty), .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we = 1'b0; exp_tk = 1'b0; exp_mis = 1'b0; exp_pc = 16'h0000;
        exp_bc = 0; exp_mc = 0; exp_bc4 = 0; exp_mc4 = 0;
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("upd_we", 32'(upd_we), 32'(exp_we));
        chk("upd_pc", 32'(upd_pc), 32'(exp_pc));
        chk("upd_taken", 32'(upd_taken), 32'(exp_tk));
        chk("mispredict", 32'(mispredict), 32'(exp_mis));
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
        chk("branch_cnt", 32'(branch_cnt), 32'(exp_bc));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(exp_mc));
        chk("sat_branch_cnt", 32'(s_branch_cnt), 32'(exp_bc4));
        chk("sat_mispred_cnt", 32'(s_mispred_cnt), 32'(exp_mc4));
        chk("sat_upd_we", 32'(s_upd_we), 32'(exp_we));
    endtask

    // One clock cycle: drive on negedge, advance model at posedge, compare after
    task automatic step(input logic v, input logic [15:0] pc, input logic t,
                        input logic p, input logic c, input logic h);
        logic        acc;
        logic [16:0] head;
        @(negedge clk);
        in_valid = v; in_pc = pc; in_taken = t; in_pred_taken = p; clr = c; upd_hold = h;
        @(posedge clk);
        acc = v && (mq.size() < DEPTH) && !c;
        if (c) begin
            mq.delete();
            exp_we  = 1'b0;
            exp_mis = 1'b0;
        end else begin
            if ((mq.size() > 0) && !h) begin
                head   = mq.pop_front();
                exp_we = 1'b1;
                exp_pc = head[16:1];
                exp_tk = head[0];
            end else begin
                exp_we = 1'b0;
            end
            if (acc) mq.push_back({pc, t});
            exp_mis = acc && (t != p);
            if (acc) begin
                if (exp_bc < 65535) exp_bc++;
                if (exp_bc4 < 15) exp_bc4++;
                if (t != p) begin
                    if (exp_mc < 65535) exp_mc++;
                    if (exp_mc4 < 15) exp_mc4++;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] base;
        rst = 1'b0; in_valid = 1'b0; in_pc = 16'h0000; in_taken = 1'b0;
        in_pred_taken = 1'b0; clr = 1'b0; upd_hold = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-traffic
        step(1'b1, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0104, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0108, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_upd_we", 32'(upd_we), 32'd0);
        chk("async_branch_cnt", 32'(branch_cnt), 32'd0);
        chk("async_mispred_cnt", 32'(mispred_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0; upd_hold = 1'b0;
        rst = 1'b1;
        repeat (4) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single mispredicted branch
        step(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_mispredict", 32'(mispredict), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_we", 32'(upd_we), 32'd1);
        chk("single_pc", 32'(upd_pc), 32'h0040);
        chk("single_taken", 32'(upd_taken), 32'd1);
        chk("single_bcnt", 32'(branch_cnt), 32'd1);
        chk("single_mcnt", 32'(mispred_cnt), 32'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_we_off", 32'(upd_we), 32'd0);

        // Fill under hold, overflow push ignored, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0010 + 4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(in_ready), 32'd0);
        step(1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fill_bcnt", 32'(branch_cnt), 32'd5);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("drain_pc", 32'(upd_pc), 32'(16'h0010 + 4 * i));
        end
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Streaming across three pointer wraps
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'(16'h0200 + 2 * i), i[0], 1'b0, 1'b0, 1'b0);
            chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush with a simultaneous push at count 2
        step(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0304, 1'b1, 1'b1, 1'b0, 1'b1);
        base = branch_cnt;
        step(1'b1, 16'h0308, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_mispredict", 32'(mispredict), 32'd0);
        chk("clr_bcnt", 32'(branch_cnt), 32'(base));
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clr_no_we", 32'(upd_we), 32'd0);

        // Saturation of the narrow-counter instance
        for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h0400 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_bcnt15", 32'(s_branch_cnt), 32'd15);
        chk("sat_mcnt15", 32'(s_mispred_cnt), 32'd15);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom % 20) == 0, ($urandom % 3) == 0);
        end
        repeat (6) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
